// File: rtl/sap1_pkg.sv
// Shared SAP-1 definitions: program-loader frame layout and loader FSM states.
package sap1_pkg;

  localparam logic [3:0] LOADER_MAGIC = 4'hA;
  localparam int         FRAME_BITS   = 16;
  localparam int         ADDR_W       = 4;
  localparam int         DATA_W       = 8;
  localparam int         FCOUNT_W     = 5;
  localparam logic [FCOUNT_W-1:0] FCOUNT_MAX = 5'd16;

  typedef enum logic [1:0] {
    LD_IDLE   = 2'd0,
    LD_SHIFT  = 2'd1,
    LD_COMMIT = 2'd2
  } loader_state_e;

endpackage

// File: rtl/sync_edge.sv
// 3-flop synchronizer for an asynchronous input, with registered rise/fall pulses
// that coincide with the cycle the synchronized level changes.
module sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [2:0] sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], d};
      rise   <= sync_q[1] & ~sync_q[2];
      fall   <= ~sync_q[1] & sync_q[2];
    end
  end

  assign level = sync_q[2];

endmodule

// File: rtl/spi_prog_loader.sv
// SPI (mode 0) program loader for SAP-1 RAM: 16-bit frames {magic, addr, data}.
// Define SPI_LOADER_MAGIC_CHECK_EN to reject frames whose top nibble is not the magic.
module spi_prog_loader
  import sap1_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                sclk_in,
  input  logic                mosi_in,
  input  logic                cs_n_in,
  output logic                wr_en,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [DATA_W-1:0]   wr_data,
  output logic                loading,
  output logic                frame_err,
  output logic [FCOUNT_W-1:0] frame_count,
  output loader_state_e       state_dbg
);

  logic sclk_level, sclk_rise, sclk_fall;
  logic mosi_level, mosi_rise, mosi_fall;
  logic cs_level, cs_rise, cs_fall;

  sync_edge u_sync_sclk (.clk(clk), .reset(reset), .d(sclk_in),
                         .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall));
  sync_edge u_sync_mosi (.clk(clk), .reset(reset), .d(mosi_in),
                         .level(mosi_level), .rise(mosi_rise), .fall(mosi_fall));
  sync_edge u_sync_cs   (.clk(clk), .reset(reset), .d(cs_n_in),
                         .level(cs_level), .rise(cs_rise), .fall(cs_fall));

  loader_state_e         state, next_state;
  logic [FRAME_BITS-1:0] shreg;
  logic [3:0]            bit_cnt;
  logic                  last_bit, shift_en, frame_ok, wr_fire, err_set;

  assign last_bit = (state == LD_SHIFT) && sclk_rise && (bit_cnt == 4'(FRAME_BITS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= LD_IDLE;
    else       state <= next_state;
  end

  // A cs_n rise together with the 16th bit still commits; COMMIT then sees cs high.
  always_comb begin
    next_state = state;
    case (state)
      LD_IDLE:   if (cs_fall) next_state = LD_SHIFT;
      LD_SHIFT: begin
        if (last_bit)     next_state = LD_COMMIT;
        else if (cs_rise) next_state = LD_IDLE;
      end
      LD_COMMIT: next_state = cs_level ? LD_IDLE : LD_SHIFT;
      default:   next_state = LD_IDLE;
    endcase
  end

  always_comb begin
    shift_en = (state == LD_SHIFT) && sclk_rise;
`ifdef SPI_LOADER_MAGIC_CHECK_EN
    frame_ok = (shreg[FRAME_BITS-1 -: 4] == LOADER_MAGIC);
`else
    frame_ok = 1'b1;
`endif
    wr_fire  = (state == LD_COMMIT) && frame_ok;
    err_set  = ((state == LD_COMMIT) && !frame_ok) ||
               ((state == LD_SHIFT) && cs_rise && !last_bit && (bit_cnt != 4'd0));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg       <= '0;
      bit_cnt     <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      loading     <= 1'b0;
      frame_err   <= 1'b0;
      frame_count <= '0;
    end else begin
      wr_en   <= wr_fire;
      loading <= (next_state != LD_IDLE);
      if (wr_fire) begin
        wr_addr <= shreg[ADDR_W+DATA_W-1 -: ADDR_W];
        wr_data <= shreg[DATA_W-1:0];
      end
      if (shift_en) shreg <= {shreg[FRAME_BITS-2:0], mosi_level};
      if (cs_fall) begin
        bit_cnt     <= '0;
        frame_err   <= 1'b0;
        frame_count <= '0;
      end else begin
        if (shift_en) bit_cnt <= bit_cnt + 4'd1;
        if (err_set)  frame_err <= 1'b1;
        if (wr_fire && frame_count != FCOUNT_MAX) frame_count <= frame_count + 5'd1;
      end
    end
  end

  assign state_dbg = state;

  logic unused_sync;
  assign unused_sync = &{1'b0, sclk_level, sclk_fall, mosi_rise, mosi_fall, cs_fall & 1'b0,
                         shreg[FRAME_BITS-1 -: 4]};

endmodule

// File: tb/tb_spi_prog_loader.sv
// Directed bench for spi_prog_loader: SPI frames at clk/8, writes captured into a scoreboard.
module tb_spi_prog_loader;
  import sap1_pkg::*;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                sclk_in = 1'b0;
  logic                mosi_in = 1'b0;
  logic                cs_n_in = 1'b1;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic                loading;
  logic                frame_err;
  logic [FCOUNT_W-1:0] frame_count;
  loader_state_e       state_dbg;

  int n_checks = 0;
  int n_pass   = 0;

  logic [11:0] exp_q[$];
  logic [11:0] got_q[$];

  spi_prog_loader dut (
    .clk(clk), .reset(reset), .sclk_in(sclk_in), .mosi_in(mosi_in), .cs_n_in(cs_n_in),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .loading(loading),
    .frame_err(frame_err), .frame_count(frame_count), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset && wr_en) got_q.push_back({wr_addr, wr_data});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // driver tasks
  task automatic cs_low();
    cs_n_in = 1'b0;
    wait_clk(8);
  endtask

  task automatic cs_high();
    wait_clk(4);
    cs_n_in = 1'b1;
    wait_clk(8);
  endtask

  task automatic send_bits(input logic [15:0] frame, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      mosi_in = frame[15-i];
      wait_clk(4);
      sclk_in = 1'b1;
      wait_clk(4);
      sclk_in = 1'b0;
    end
  endtask

  task automatic expect_write(input logic [3:0] a, input logic [7:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0)
      check({tag, "_write"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    wait_clk(3);
    check("rst_wr_en", 32'(wr_en), 0);
    check("rst_wr_addr", 32'(wr_addr), 0);
    check("rst_wr_data", 32'(wr_data), 0);
    check("rst_loading", 32'(loading), 0);
    check("rst_frame_err", 32'(frame_err), 0);
    check("rst_frame_count", 32'(frame_count), 0);
    check("rst_state", 32'(state_dbg), 32'(LD_IDLE));
    reset = 1'b0;
    wait_clk(8);

    // single frame
    cs_low();
    check("single_loading", 32'(loading), 1);
    send_bits(16'hA50F, 16);
    cs_high();
    expect_write(4'h5, 8'h0F);
    check_writes("single");
    check("single_count", 32'(frame_count), 1);
    check("single_err", 32'(frame_err), 0);
    check("single_loading_off", 32'(loading), 0);

    // full image, then loading release timing
    cs_low();
    for (int i = 0; i < 16; i++) begin
      send_bits({4'hA, 4'(i), 8'((i * 2) % 20)}, 16);
      expect_write(4'(i), 8'((i * 2) % 20));
    end
    wait_clk(4);
    check("image_loading_hi", 32'(loading), 1);
    cs_n_in = 1'b1;
    wait_clk(3);
    check("image_loading_sync", 32'(loading), 1);
    wait_clk(1);
    check("image_loading_lo", 32'(loading), 0);
    wait_clk(4);
    check_writes("image");
    check("image_count", 32'(frame_count), 16);
    check("image_err", 32'(frame_err), 0);

    // truncated frame
    cs_low();
    send_bits(16'hA123, 11);
    cs_high();
    check_writes("trunc");
    check("trunc_err", 32'(frame_err), 1);
    cs_low();
    check("trunc_err_clear", 32'(frame_err), 0);
    cs_high();
    check("trunc_empty_err", 32'(frame_err), 0);

    // bad magic nibble
    cs_low();
    send_bits(16'h330C, 16);
    cs_high();
`ifdef SPI_LOADER_MAGIC_CHECK_EN
    check("magic_err", 32'(frame_err), 1);
    check("magic_count", 32'(frame_count), 0);
`else
    expect_write(4'h3, 8'h0C);
    check("magic_err", 32'(frame_err), 0);
    check("magic_count", 32'(frame_count), 1);
`endif
    check_writes("magic");

    // same address twice in one session
    cs_low();
    send_bits(16'hA211, 16);
    send_bits(16'hA222, 16);
    cs_high();
    expect_write(4'h2, 8'h11);
    expect_write(4'h2, 8'h22);
    check_writes("dup");
    check("dup_count", 32'(frame_count), 2);

    // cs_n rise together with the 16th sclk edge still commits
    cs_low();
    send_bits(16'hA7C3, 15);
    mosi_in = 1'b1;
    wait_clk(4);
    sclk_in = 1'b1;
    cs_n_in = 1'b1;
    wait_clk(4);
    sclk_in = 1'b0;
    wait_clk(12);
    expect_write(4'h7, 8'hC3);
    check_writes("edge_commit");
    check("edge_count", 32'(frame_count), 1);
    check("edge_err", 32'(frame_err), 0);
    check("edge_state", 32'(state_dbg), 32'(LD_IDLE));

    // reset mid-frame
    cs_low();
    send_bits(16'hA9FF, 8);
    reset = 1'b1;
    #1;
    check("mid_rst_wr_en", 32'(wr_en), 0);
    check("mid_rst_loading", 32'(loading), 0);
    check("mid_rst_count", 32'(frame_count), 0);
    check("mid_rst_err", 32'(frame_err), 0);
    check("mid_rst_addr_data", 32'({wr_addr, wr_data}), 0);
    wait_clk(3);
    reset = 1'b0;
    mosi_in = 1'b0;
    wait_clk(4);
    cs_n_in = 1'b1;
    wait_clk(8);
    check_writes("mid_rst");
    cs_low();
    send_bits(16'hA1AA, 16);
    cs_high();
    expect_write(4'h1, 8'hAA);
    check_writes("post_rst");
    check("post_rst_count", 32'(frame_count), 1);

    // saturation
    cs_low();
    for (int i = 0; i < 18; i++) begin
      send_bits({4'hA, 4'(i % 16), 8'(i + 8'h40)}, 16);
      expect_write(4'(i % 16), 8'(i + 8'h40));
    end
    cs_high();
    check_writes("sat");
    check("sat_count", 32'(frame_count), 16);
    check("sat_err", 32'(frame_err), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_prog_loader.md
SPI_PROG_LOADER -- requirements
Module: spi_prog_loader

Interface
REQ-001 SHALL have a single clock and an asynchronous, active-high reset, with ports named `clk` and `reset`.
REQ-002 SHALL have port `clk`: input, 1 bit, 100 MHz system clock.
REQ-003 SHALL have port `reset`: input, 1 bit, asynchronous active-high reset.
REQ-004 SHALL have port `sclk_in`: input, 1 bit, host SPI clock, mode 0, asynchronous to `clk`, at most `clk`/8.
REQ-005 SHALL have port `mosi_in`: input, 1 bit, host serial data, MSB first.
REQ-006 SHALL have port `cs_n_in`: input, 1 bit, host chip select, active low, asynchronous.
REQ-007 SHALL have port `wr_en`: output, 1 bit, one-`clk` write strobe to program RAM.
REQ-008 SHALL have port `wr_addr`: output, 4 bits, RAM address; valid while `wr_en` is high.
REQ-009 SHALL have port `wr_data`: output, 8 bits, RAM byte; valid while `wr_en` is high.
REQ-010 SHALL have port `loading`: output, 1 bit, high during a session; it is ORed into the SAP-1 `sys_reset`.
REQ-011 SHALL have port `frame_err`: output, 1 bit, sticky error flag for the last session.
REQ-012 SHALL have port `frame_count`: output, 5 bits, number of good frames written in the current or last session.

Function
REQ-013 SHALL pass `sclk_in`, `mosi_in` and `cs_n_in` each through a 3-flop synchronizer; edges are detected on synchronized values only.
REQ-014 SHALL run an FSM with states IDLE, SHIFT and COMMIT.
- IDLE -> SHIFT on a synchronized `cs_n` fall.
- SHIFT -> COMMIT when the 16th bit of a frame is sampled.
- COMMIT -> SHIFT after exactly 1 cycle.
- Any state -> IDLE on a synchronized `cs_n` rise.
REQ-015 SHALL shift in the synchronized `mosi` value on each synchronized `sclk` rising edge while in SHIFT, into a 16-bit shift register; the 4-bit bit counter wraps from 15 to 0.
REQ-016 SHALL interpret each frame as follows: bits [15:12] are the magic nibble 4'hA, bits [11:8] are the address, and bits [7:0] are the data.
REQ-017 SHALL, in COMMIT for a valid frame, assert `wr_en` for 1 cycle with `wr_addr` and `wr_data` taken from the frame, and increment `frame_count`, saturating at 16.
REQ-018 SHALL set `wr_en` to 2 cycles after the synchronized `sclk` edge that carries the 16th bit.
REQ-019 SHALL assert `loading` from the cycle after the synchronized `cs_n` fall until the cycle after the synchronized `cs_n` rise.
REQ-020 SHALL, on a synchronized `cs_n` fall, clear `frame_err` and `frame_count` and reset the bit counter to 0.
REQ-021 SHALL, on a `cs_n` rise with the bit counter not equal to 0, set `frame_err` and discard the partial frame without writing.
REQ-022 SHALL, when a frame's magic nibble is not 4'hA, skip the write and set `frame_err`; the following frames are still processed.
REQ-023 SHALL give a `cs_n` rise in the same cycle as the 16th-bit sample priority to COMMIT: the write occurs, then the FSM goes to IDLE.
REQ-024 SHALL ignore `sclk` edges while `cs_n` is high.
REQ-025 SHALL treat a second write to the same address within a session as legal; the last write wins, and it counts as a frame.

Reset
REQ-026 SHALL on `reset` put the FSM in IDLE and clear the synchronizers, shift register and bit counter to 0.
REQ-027 SHALL on `reset` drive `wr_en`=0, `wr_addr`=0, `wr_data`=0, `loading`=0, `frame_err`=0, `frame_count`=0.
REQ-028 SHALL abort any session in progress when reset is asserted, with no write; after release, it waits for a new `cs_n` fall.

Configuration
REQ-029 SHALL implement the magic-nibble check (REQ-022) when `SPI_LOADER_MAGIC_CHECK_EN` is defined.
REQ-030 SHALL, when `SPI_LOADER_MAGIC_CHECK_EN` is undefined, ignore bits [15:12], write every complete frame, and set `frame_err` only via REQ-021.

Structure
REQ-031 SHALL keep the following in shared package `sap1_pkg`: `LOADER_MAGIC` (4'hA), `FRAME_BITS` (16), `ADDR_W` (4), `DATA_W` (8), and the loader state enum.
REQ-032 SHALL use one sub-module, `sync_edge`: a 3-flop synchronizer with registered rise and fall pulses, instanced three times.

Verification
REQ-033 SHALL cover a single frame: `cs_n` low, frame 0xA50F sent at `clk`/8, `cs_n` high -> one `wr_en` pulse with `wr_addr`=5 and `wr_data`=0x0F; then `frame_count`=1 and `frame_err`=0.
REQ-034 SHALL cover a full image: 16 frames 0xA000..0xAF0A in one session -> 16 strobes with addresses 0..15 in order, `frame_count`=16, and `loading` high throughout and low 1 cycle after `cs_n` rises.
REQ-035 SHALL cover a truncated frame: 11 bits then `cs_n` high -> no `wr_en`, `frame_err`=1; a new `cs_n` fall clears `frame_err` to 0.
REQ-036 SHALL cover a bad magic nibble: frame 0x330C -> with `SPI_LOADER_MAGIC_CHECK_EN`, no write and `frame_err`=1; without it, a write with `wr_addr`=3 and `wr_data`=0x0C.
REQ-037 SHALL cover reset mid-frame: `reset` pulsed after 8 bits -> all outputs 0 and no write; a following fresh frame 0xA1AA writes `wr_addr`=1, `wr_data`=0xAA.
REQ-038 SHALL cover saturation: 18 valid frames -> `frame_count` holds at 16 and 18 `wr_en` pulses are observed.
